// File: rtl/fetch_queue_if.sv
// Instruction-bus bundle between the fetch stage (master) and memory (slave).
// One outstanding request at a time: the master raises ireq_valid with a
// stable ireq_addr until the slave answers with iresp_data_ok/iresp_data.
interface fetch_queue_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry decoupling queue.
// Issues sequential fetches on the instruction bus, buffers returned
// instructions in order and presents the head to decode. A redirect
// (flushall, else branch) discards queued entries and any in-flight fetch.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives while the queue is empty and decode is not stalled is forwarded
// combinationally to dataF instead of being written into the queue.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch,
    input  logic [63:0]       jump,
    input  logic              flushall,
    input  logic [63:0]       csrpc,
    input  logic              stop,
    fetch_queue_if.master     ibus,
    output logic              dataf_valid,
    output logic [31:0]       dataf_instr,
    output logic [63:0]       dataf_pc,
    output logic              stopf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [63:0]        addr_q, addr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]        instr_mem [DEPTH];
    logic [63:0]        pc_mem    [DEPTH];

    logic               redirect;
    logic [63:0]        target;
    logic               head_valid;
    logic               bypass_hit;
    logic               enq;
    logic               deq;
    logic               free;

    // Next-state logic: redirect, queue bookkeeping and the fetch FSM.
    always_comb begin
        redirect   = flushall | branch;
        target     = flushall ? csrpc : jump;
        head_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
        bypass_hit = !head_valid && (state_q == REQ) && ibus.iresp_data_ok
                     && !stop && !redirect;
`else
        bypass_hit = 1'b0;
`endif

        // A redirect wins over any enqueue/dequeue happening in the same cycle.
        deq = head_valid && !stop && !redirect;
        enq = (state_q == REQ) && ibus.iresp_data_ok && !redirect && !bypass_hit;

        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        end

        // Fetch PC advances on every accepted response (queued or bypassed).
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target;
        end else if ((state_q == REQ) && ibus.iresp_data_ok) begin
            pc_d = pc_q + 64'd4;
        end

        // 'free' means no request survives this cycle, so the FSM passes
        // through IDLE and may issue the next fetch straight away.
        free    = 1'b0;
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: free = 1'b1;
            REQ: begin
                if (ibus.iresp_data_ok) begin
                    free = 1'b1;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (ibus.iresp_data_ok) begin
                    free = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Issue only while a slot is left for the entry this fetch will return.
        if (free) begin
            if (count_d < DEPTH_C) begin
                state_d = REQ;
                valid_d = 1'b1;
                addr_d  = pc_d;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end
    end

    // Control state and registered bus request, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q] <= ibus.iresp_data;
            pc_mem[wr_ptr_q]    <= addr_q;
        end
    end

    assign ibus.ireq_valid = valid_q;
    assign ibus.ireq_addr  = addr_q;

    // Decode-side view: bypassed response, else queue head, else zeros.
    always_comb begin
        dataf_valid = head_valid | bypass_hit;
        dataf_instr = 32'd0;
        dataf_pc    = 64'd0;
        if (bypass_hit) begin
            dataf_instr = ibus.iresp_data;
            dataf_pc    = addr_q;
        end else if (head_valid) begin
            dataf_instr = instr_mem[rd_ptr_q];
            dataf_pc    = pc_mem[rd_ptr_q];
        end
        stopf = !dataf_valid;
    end

endmodule
